// File: rtl/mac_pe_pipe.sv
// Pipelined signed multiply-accumulate PE for the systolic matrix multiplier; forwards operands east/south.
// Latency: pair presented in cycle N is in S1 after edge N+1, product after N+2, result valid after edge N+3.
// Backpressure: if a finished sum is unread and the next last term reaches S2, the whole pipe freezes and in_ready drops.
//
// Optional feature macro: MAC_PE_PIPE_SAT_EN (saturating accumulate + sticky ovf); undefined = wrapping add, ovf tied 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake; in_first/in_last frame a dot product
//   a_in, b_in                       signed operands (DATA_W)
//   a_out, b_out, fwd_*              registered S1 copy forwarded to neighbouring PEs
//   res_valid/res_ready, res_data    completed dot product (ACC_W), valid/ready
//   ovf                              sticky saturation flag
module mac_pe_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     fwd_valid,
    output logic                     fwd_first,
    output logic                     fwd_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic                     ovf
);
    localparam int PROD_W = 2 * DATA_W;

    // S1: operand register, doubles as the forwarding register
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic signed [DATA_W-1:0] r_s1_a;
    logic signed [DATA_W-1:0] r_s1_b;
    // S2: full-width product
    logic                     r_s2_valid;
    logic                     r_s2_first;
    logic                     r_s2_last;
    logic signed [PROD_W-1:0] r_s2_prod;
    // S3: accumulator and result holding register
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_res_valid;
    logic signed [ACC_W-1:0]  r_res_data;

    logic                     w_stall;
    logic                     w_adv_acc;
    logic                     w_load;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_next;

    // Only a second finished sum can collide with an unread result, so the
    // freeze is limited to that case; everything else keeps flowing.
    assign w_stall   = r_res_valid && !res_ready && r_s2_valid && r_s2_last;
    assign w_adv_acc = !w_stall && r_s2_valid;
    assign w_load    = w_adv_acc && r_s2_last;

    // Operands are sign-extended to the product width first, so
    // -2^(W-1) * -2^(W-1) is exact.
    assign w_prod     = PROD_W'(r_s1_a) * PROD_W'(r_s1_b);
    assign w_prod_ext = ACC_W'(r_s2_prod);

`ifdef MAC_PE_PIPE_SAT_EN
    logic signed [ACC_W:0] w_sum;
    logic                  w_clamp;
    logic                  r_ovf;

    // One guard bit: the add overflowed iff the top two bits disagree.
    assign w_sum   = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
    assign w_clamp = w_sum[ACC_W] != w_sum[ACC_W-1];

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (r_s2_first) begin
            // A single product always fits because ACC_W >= 2*DATA_W.
            w_acc_next = w_prod_ext;
        end else if (w_clamp) begin
            w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Sticky until reset; a new dot product does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv_acc && !r_s2_first && w_clamp) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic signed [ACC_W-1:0] w_sum;

    assign w_sum      = r_acc + w_prod_ext;
    assign w_acc_next = r_s2_first ? w_prod_ext : w_sum;
    assign ovf        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_first  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_prod   <= '0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (!w_stall) begin
                // in_ready is high whenever we get here, so in_valid is the accept
                r_s1_valid <= in_valid;
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_s1_a     <= a_in;
                r_s1_b     <= b_in;
                r_s2_valid <= r_s1_valid;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_prod  <= w_prod;
            end
            // Bubbles leave the accumulator untouched.
            if (w_adv_acc) begin
                r_acc <= w_acc_next;
            end
            // Load wins over take: a same-cycle take and load keeps valid high.
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_acc_next;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = !w_stall;
    // Suppressed while frozen so a neighbour never counts a held pair twice.
    assign fwd_valid = r_s1_valid && !w_stall;
    assign fwd_first = r_s1_first;
    assign fwd_last  = r_s1_last;
    assign a_out     = r_s1_a;
    assign b_out     = r_s1_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_mac_pe_pipe.sv
// Bench for mac_pe_pipe: two instances (ACC_W=32 and ACC_W=16) share one operand stream.
// A transaction-level dot-product model predicts forwarded pairs and results; directed
// literal checks pin latency, backpressure, reset and the model's own results.
module tb_mac_pe_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic        res_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;

    logic        ir0, fv0, ff0, fl0, rv0, ov0;
    logic [7:0]  ao0, bo0;
    logic [31:0] rd0;
    logic        ir1, fv1, ff1, fl1, rv1, ov1;
    logic [7:0]  ao1, bo1;
    logic [15:0] rd1;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MAC_PE_PIPE_SAT_EN
    localparam bit     SATB  = 1'b1;
    localparam longint OVF16 = 32767;
`else
    localparam bit     SATB  = 1'b0;
    localparam longint OVF16 = -17149;
`endif

    mac_pe_pipe #(.DATA_W(8), .ACC_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir0), .in_first(in_first), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(ao0), .b_out(bo0),
        .fwd_valid(fv0), .fwd_first(ff0), .fwd_last(fl0),
        .res_valid(rv0), .res_ready(res_ready), .res_data(rd0), .ovf(ov0)
    );

    mac_pe_pipe #(.DATA_W(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir1), .in_first(in_first), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(ao1), .b_out(bo1),
        .fwd_valid(fv1), .fwd_first(ff1), .fwd_last(fl1),
        .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .ovf(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state (per instance) ----------------
    logic [17:0] flog [2][256];   // {first,last,a,b} in accept order
    int          fwr  [2];
    int          frd  [2];
    longint      rexp [2][64];    // expected results in completion order
    bit          rovf [2][64];
    int          rwr  [2];
    int          rrd  [2];
    longint      m_acc[2];
    bit          m_ovf[2];
    bit          prev_rv[2];
    bit          prev_take[2];
    longint      cur  [2];
    longint      mlog [2][16];    // every result the model produced, never cleared
    int          nlog [2];
    longint      pin0 [10];
    longint      pin1 [10];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    task automatic mon(input int i, input logic ir, input logic fv, input logic ff,
                       input logic fl, input logic [7:0] ao, input logic [7:0] bo,
                       input logic rv, input longint rdat, input logic ov, input int w);
        logic [17:0] e;
        longint p, s, hi, lo;
        bit pres;
        if (!rst_n) begin
            fwr[i] = 0; frd[i] = 0; rwr[i] = 0; rrd[i] = 0;
            prev_rv[i] = 0; prev_take[i] = 0; m_ovf[i] = 0;
        end else begin
            // forwarded pairs: each accepted pair exactly once, in order
            if (fv) begin
                if (frd[i] >= fwr[i]) begin
                    chk($sformatf("fwd_extra%0d", i), longint'(fv), 0);
                end else begin
                    e = flog[i][frd[i]];
                    chk($sformatf("fwd_a%0d", i), longint'($signed(ao)), longint'($signed(e[15:8])));
                    chk($sformatf("fwd_b%0d", i), longint'($signed(bo)), longint'($signed(e[7:0])));
                    chk($sformatf("fwd_first%0d", i), longint'(ff), longint'(e[17]));
                    chk($sformatf("fwd_last%0d", i), longint'(fl), longint'(e[16]));
                    frd[i]++;
                end
            end
            // a new result is presented when valid rises or right after a take
            pres = rv && (!prev_rv[i] || prev_take[i]);
            if (pres) begin
                if (rrd[i] >= rwr[i]) begin
                    chk($sformatf("res_extra%0d", i), longint'(rv), 0);
                end else begin
                    chk($sformatf("res_data%0d", i), rdat, rexp[i][rrd[i]]);
                    chk($sformatf("ovf%0d", i), longint'(ov), longint'(rovf[i][rrd[i]]));
                    cur[i] = rexp[i][rrd[i]];
                    rrd[i]++;
                end
            end
            if (rv && res_ready) chk($sformatf("res_take%0d", i), rdat, cur[i]);
            if (res_ready || !rv) chk($sformatf("in_ready%0d", i), longint'(ir), 1);
            prev_rv[i]   = rv;
            prev_take[i] = rv && res_ready;
            // accept: dot-product arithmetic at transaction level
            if (in_valid && ir) begin
                if (fwr[i] < 256) begin
                    flog[i][fwr[i]] = {in_first, in_last, a_in, b_in};
                    fwr[i]++;
                end
                p  = longint'($signed(a_in)) * longint'($signed(b_in));
                hi = (longint'(1) <<< (w - 1)) - 1;
                lo = -(longint'(1) <<< (w - 1));
                if (in_first) begin
                    s = p;
                end else begin
                    s = m_acc[i] + p;
                    if (SATB) begin
                        if (s > hi) begin s = hi; m_ovf[i] = 1; end
                        else if (s < lo) begin s = lo; m_ovf[i] = 1; end
                    end else begin
                        s = wrapw(s, w);
                    end
                end
                m_acc[i] = s;
                if (in_last && rwr[i] < 64) begin
                    rexp[i][rwr[i]] = s;
                    rovf[i][rwr[i]] = m_ovf[i];
                    rwr[i]++;
                    if (nlog[i] < 16) begin
                        mlog[i][nlog[i]] = s;
                        nlog[i]++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ir0, fv0, ff0, fl0, ao0, bo0, rv0, longint'($signed(rd0)), ov0, 32);
        mon(1, ir1, fv1, ff1, fl1, ao1, bo1, rv1, longint'($signed(rd1)), ov1, 16);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic nck();
        @(negedge clk); #1;
    endtask

    // Called just after a rising edge; returns just after the edge that captured the pair.
    task automatic send(input int a, input int b, input logic f, input logic l);
        bit ok;
        int n;
        a_in = 8'(a); b_in = 8'(b); in_first = f; in_last = l; in_valid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ir0;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) chk("send_timeout", longint'(ir0), 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pin0 = '{56, 16384, -16129, 10, 14, 30, 22, 48387, 1, 20};
        pin1 = '{56, 16384, -16129, 10, 14, 30, 22, OVF16, 1, 20};
        for (int i = 0; i < 2; i++) begin
            nlog[i] = 0; fwr[i] = 0; frd[i] = 0; rwr[i] = 0; rrd[i] = 0;
            m_acc[i] = 0; m_ovf[i] = 0; prev_rv[i] = 0; prev_take[i] = 0; cur[i] = 0;
        end
        rst_n = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a_in = '0; b_in = '0; res_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", longint'(rv0), 0);
        chk("rst_res_data", longint'(rd0), 0);
        chk("rst_fwd_valid", longint'(fv0), 0);
        chk("rst_a_out", longint'(ao0), 0);
        chk("rst_ovf16", longint'(ov1), 0);
        chk("rst_in_ready", longint'(ir0), 1);
        rst_n = 1'b1;
        step();

        // [2,3,4].[5,6,7] = 56, result 3 cycles after the last accept, one-cycle pulse
        send(2, 5, 1, 0);
        send(3, 6, 0, 0);
        send(4, 7, 0, 1);
        nck();
        chk("t1_fwd_valid", longint'(fv0), 1);
        chk("t1_a_out", longint'($signed(ao0)), 4);
        chk("t1_b_out", longint'($signed(bo0)), 7);
        chk("t1_fwd_last", longint'(fl0), 1);
        chk("t1_early0", longint'(rv0), 0);
        nck();
        chk("t1_early1", longint'(rv0), 0);
        nck();
        chk("t1_valid", longint'(rv0), 1);
        chk("t1_data32", longint'($signed(rd0)), 56);
        chk("t1_data16", longint'($signed(rd1)), 56);
        nck();
        chk("t1_pulse", longint'(rv0), 0);
        repeat (3) step();

        // back-to-back one-term dot products
        send(-128, -128, 1, 1);
        send(127, -127, 1, 1);
        nck();
        nck();
        chk("t2_first32", longint'($signed(rd0)), 16384);
        chk("t2_first16", longint'($signed(rd1)), 16384);
        nck();
        chk("t2_second_valid", longint'(rv0), 1);
        chk("t2_second32", longint'($signed(rd0)), -16129);
        chk("t2_second16", longint'($signed(rd1)), -16129);
        repeat (3) step();

        // backpressure: 10 held, stream 1*2+3*4 reaches S2, 5*6 stuck in S1
        res_ready = 1'b0;
        send(2, 5, 1, 1);
        send(1, 2, 1, 0);
        send(3, 4, 0, 1);
        send(5, 6, 1, 1);
        for (int k = 0; k < 3; k++) begin
            nck();
            chk("t3_in_ready_low", longint'(ir0), 0);
            chk("t3_fwd_frozen", longint'(fv0), 0);
            chk("t3_held", longint'($signed(rd0)), 10);
        end
        step();
        res_ready = 1'b1;
        nck();
        chk("t3_release_ready", longint'(ir0), 1);
        chk("t3_release_fwd", longint'(fv0), 1);
        chk("t3_release_a", longint'($signed(ao0)), 5);
        chk("t3_release_data", longint'($signed(rd0)), 10);
        step();
        res_ready = 1'b0;
        nck();
        chk("t3_second_valid", longint'(rv0), 1);
        chk("t3_second_data", longint'($signed(rd0)), 14);
        step();
        res_ready = 1'b1;
        repeat (6) step();

        // bubble inside a dot product: 5*3 + 7*1 = 22
        send(5, 3, 1, 0);
        step();
        send(7, 1, 0, 1);
        repeat (6) step();

        // 127*127 three times: 48387 at 32 bits, wrap/clamp at 16 bits; then 1*1
        send(127, 127, 1, 0);
        send(127, 127, 0, 0);
        send(127, 127, 0, 1);
        repeat (5) step();
        send(1, 1, 1, 1);
        repeat (5) step();
        chk("t5_ovf16_sticky", longint'(ov1), longint'(SATB));
        chk("t5_ovf32", longint'(ov0), 0);

        // reset mid-stream discards the partial sum and clears everything at once
        send(5, 3, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_a_out", longint'(ao0), 0);
        chk("t6_b_out", longint'(bo0), 0);
        chk("t6_fwd_valid", longint'(fv0), 0);
        chk("t6_fwd_first", longint'(ff0), 0);
        chk("t6_res_valid", longint'(rv0), 0);
        chk("t6_res_data32", longint'(rd0), 0);
        chk("t6_res_data16", longint'(rd1), 0);
        chk("t6_ovf16", longint'(ov1), 0);
        step();
        rst_n = 1'b1;
        step();
        send(4, 4, 1, 0);
        send(2, 2, 0, 1);
        repeat (6) step();

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pending_res%0d", i), longint'(rwr[i] - rrd[i]), 0);
            chk($sformatf("pending_fwd%0d", i), longint'(fwr[i] - frd[i]), 0);
            chk($sformatf("model_count%0d", i), longint'(nlog[i]), 10);
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("model32_%0d", k), mlog[0][k], pin0[k]);
            chk($sformatf("model16_%0d", k), mlog[1][k], pin1[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
